// File: rtl/gpu_pkg.sv
// Shared GPU definitions: opcode constants, default field widths and the
// packed instruction record handed from the command decoder to the rasterizer.
package gpu_pkg;

    localparam logic [3:0] OP_RESET     = 4'b0000;
    localparam logic [3:0] OP_SET_XY1   = 4'b0001;
    localparam logic [3:0] OP_SET_XY2   = 4'b0010;
    localparam logic [3:0] OP_SET_RAD   = 4'b0011;
    localparam logic [3:0] OP_DRAW_LINE = 4'b0100;
    localparam logic [3:0] OP_DRAW_RECT = 4'b0101;

    localparam int GPU_WIDTH_BITS   = 10;
    localparam int GPU_HEIGHT_BITS  = 9;
    localparam int GPU_CHANNEL_BITS = 8;

    typedef struct packed {
        logic [3:0]                  opcode;
        logic [GPU_WIDTH_BITS-1:0]   x1;
        logic [GPU_HEIGHT_BITS-1:0]  y1;
        logic [GPU_WIDTH_BITS-1:0]   x2;
        logic [GPU_HEIGHT_BITS-1:0]  y2;
        logic [GPU_WIDTH_BITS-1:0]   rad;
        logic [GPU_CHANNEL_BITS-1:0] r;
        logic [GPU_CHANNEL_BITS-1:0] g;
        logic [GPU_CHANNEL_BITS-1:0] b;
    } gpu_instr_t;

    function automatic logic is_draw(input logic [3:0] op);
        return (op == OP_DRAW_LINE) || (op == OP_DRAW_RECT);
    endfunction

endpackage

// File: rtl/gpu_sync_fifo.sv
// Generic show-ahead synchronous FIFO; the head entry is read combinationally
// and the occupancy counter tells full apart from empty when pointers meet.
module gpu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_BITS   = $clog2(DEPTH);
    localparam int COUNT_BITS = $clog2(DEPTH+1);
    localparam logic [COUNT_BITS-1:0] FULL_COUNT = COUNT_BITS'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [COUNT_BITS-1:0] count_q;
    logic [COUNT_BITS-1:0] count_next;
    logic                  full_q;
    logic                  pop_ok;
    logic                  push_ok;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && (!full_q || pop_ok);

    always_comb begin
        count_next = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_next;
            full_q  <= (count_next == FULL_COUNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign valid = (count_q != '0);
    assign full  = full_q;
    assign count = count_q;

endmodule

// File: rtl/gpu_instruction_buffer.sv
// Holds the current draw parameters, snapshots them with the command colour on
// each draw, and queues the assembled instructions for the rasterizer.
module gpu_instruction_buffer
    import gpu_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       command_i,
    input  logic [3:0]                 opcode_i,
    input  logic [WIDTH_BITS-1:0]      x1_i,
    input  logic [HEIGHT_BITS-1:0]     y1_i,
    input  logic [WIDTH_BITS-1:0]      x2_i,
    input  logic [HEIGHT_BITS-1:0]     y2_i,
    input  logic [WIDTH_BITS-1:0]      rad_i,
    input  logic [CHANNEL_BITS-1:0]    r_i,
    input  logic [CHANNEL_BITS-1:0]    g_i,
    input  logic [CHANNEL_BITS-1:0]    b_i,
    input  logic                       write_enable_i,
    input  logic                       push_instruction_i,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [3:0]                 instr_opcode_o,
    output logic [WIDTH_BITS-1:0]      instr_x1_o,
    output logic [HEIGHT_BITS-1:0]     instr_y1_o,
    output logic [WIDTH_BITS-1:0]      instr_x2_o,
    output logic [HEIGHT_BITS-1:0]     instr_y2_o,
    output logic [WIDTH_BITS-1:0]      instr_rad_o,
    output logic [CHANNEL_BITS-1:0]    instr_r_o,
    output logic [CHANNEL_BITS-1:0]    instr_g_o,
    output logic [CHANNEL_BITS-1:0]    instr_b_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int INSTR_BITS = 4 + 3*WIDTH_BITS + 2*HEIGHT_BITS + 3*CHANNEL_BITS;

    logic [WIDTH_BITS-1:0]  x1_q;
    logic [HEIGHT_BITS-1:0] y1_q;
    logic [WIDTH_BITS-1:0]  x2_q;
    logic [HEIGHT_BITS-1:0] y2_q;
    logic [WIDTH_BITS-1:0]  rad_q;
    logic                   overflow_q;
    logic                   soft_clear;
    logic                   draw;
    logic                   pop;
    logic [INSTR_BITS-1:0]  push_data;
    logic [INSTR_BITS-1:0]  head_data;

    assign soft_clear = command_i && (opcode_i == OP_RESET);
    assign draw       = push_instruction_i && is_draw(opcode_i);
    assign pop        = instr_valid_o && instr_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || soft_clear) begin
            x1_q  <= '0;
            y1_q  <= '0;
            x2_q  <= '0;
            y2_q  <= '0;
            rad_q <= '0;
        end else if (write_enable_i && !push_instruction_i) begin
            case (opcode_i)
                OP_SET_XY1: begin
                    x1_q <= x1_i;
                    y1_q <= y1_i;
                end
                OP_SET_XY2: begin
                    x2_q <= x2_i;
                    y2_q <= y2_i;
                end
                OP_SET_RAD: rad_q <= rad_i;
                default: ;
            endcase
        end
    end

    // Sticky until reset or soft clear; a dropped draw leaves the FIFO untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i || soft_clear) begin
            overflow_q <= 1'b0;
        end else if (draw && full_o && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign push_data = {opcode_i, x1_q, y1_q, x2_q, y2_q, rad_q, r_i, g_i, b_i};

    gpu_sync_fifo #(
        .WIDTH (INSTR_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (soft_clear),
        .push  (draw),
        .pop   (pop),
        .wdata (push_data),
        .rdata (head_data),
        .valid (instr_valid_o),
        .full  (full_o),
        .count (count_o)
    );

    assign {instr_opcode_o, instr_x1_o, instr_y1_o, instr_x2_o, instr_y2_o,
            instr_rad_o, instr_r_o, instr_g_o, instr_b_o} = head_data;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_gpu_instruction_buffer.sv
// Self-checking bench for gpu_instruction_buffer: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_gpu_instruction_buffer;
    import gpu_pkg::*;

    localparam int DEPTH = 8;
    localparam int WB    = 10;
    localparam int HB    = 9;
    localparam int CB    = 8;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          command_i = 1'b0;
    logic [3:0]    opcode_i = '0;
    logic [WB-1:0] x1_i = '0;
    logic [HB-1:0] y1_i = '0;
    logic [WB-1:0] x2_i = '0;
    logic [HB-1:0] y2_i = '0;
    logic [WB-1:0] rad_i = '0;
    logic [CB-1:0] r_i = '0;
    logic [CB-1:0] g_i = '0;
    logic [CB-1:0] b_i = '0;
    logic          write_enable_i = 1'b0;
    logic          push_instruction_i = 1'b0;
    logic          instr_valid_o;
    logic          instr_ready_i = 1'b0;
    logic [3:0]    instr_opcode_o;
    logic [WB-1:0] instr_x1_o;
    logic [HB-1:0] instr_y1_o;
    logic [WB-1:0] instr_x2_o;
    logic [HB-1:0] instr_y2_o;
    logic [WB-1:0] instr_rad_o;
    logic [CB-1:0] instr_r_o;
    logic [CB-1:0] instr_g_o;
    logic [CB-1:0] instr_b_o;
    logic          full_o;
    logic [3:0]    count_o;
    logic          overflow_o;

    int checks = 0;
    int passed = 0;

    // Reference model state: the queued instructions and the parameter set.
    gpu_instr_t    model_q[$];
    logic [WB-1:0] m_x1, m_x2, m_rad;
    logic [HB-1:0] m_y1, m_y2;
    logic          m_ovf;

    gpu_instruction_buffer #(
        .DEPTH(DEPTH), .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .command_i(command_i), .opcode_i(opcode_i),
        .x1_i(x1_i), .y1_i(y1_i), .x2_i(x2_i), .y2_i(y2_i), .rad_i(rad_i),
        .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .write_enable_i(write_enable_i), .push_instruction_i(push_instruction_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_opcode_o(instr_opcode_o),
        .instr_x1_o(instr_x1_o), .instr_y1_o(instr_y1_o),
        .instr_x2_o(instr_x2_o), .instr_y2_o(instr_y2_o),
        .instr_rad_o(instr_rad_o),
        .instr_r_o(instr_r_o), .instr_g_o(instr_g_o), .instr_b_o(instr_b_o),
        .full_o(full_o), .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    function automatic logic [75:0] head_bits();
        return {instr_opcode_o, instr_x1_o, instr_y1_o, instr_x2_o, instr_y2_o,
                instr_rad_o, instr_r_o, instr_g_o, instr_b_o};
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        gpu_instr_t e;
        bit clear_m, pop_m, push_acc;
        clear_m  = command_i && (opcode_i == 4'b0000);
        pop_m    = (model_q.size() != 0) && instr_ready_i;
        push_acc = 0;
        e        = '0;
        if (rst_i || clear_m) begin
            model_q.delete();
            m_x1 = '0; m_y1 = '0; m_x2 = '0; m_y2 = '0; m_rad = '0;
            m_ovf = 1'b0;
        end else begin
            if (push_instruction_i && (opcode_i == 4'b0100 || opcode_i == 4'b0101)) begin
                if (model_q.size() == DEPTH && !pop_m) begin
                    m_ovf = 1'b1;
                end else begin
                    push_acc = 1;
                    e = '{opcode: opcode_i, x1: m_x1, y1: m_y1, x2: m_x2, y2: m_y2,
                          rad: m_rad, r: r_i, g: g_i, b: b_i};
                end
            end
            if (pop_m) model_q.delete(0);
            if (push_acc) model_q.push_back(e);
            if (write_enable_i && !push_instruction_i) begin
                if (opcode_i == 4'b0001) begin m_x1 = x1_i; m_y1 = y1_i; end
                if (opcode_i == 4'b0010) begin m_x2 = x2_i; m_y2 = y2_i; end
                if (opcode_i == 4'b0011) m_rad = rad_i;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_i = 0; command_i = 0; opcode_i = '0;
        write_enable_i = 0; push_instruction_i = 0; instr_ready_i = 0;
        x1_i = WB'($urandom); y1_i = HB'($urandom);
        x2_i = WB'($urandom); y2_i = HB'($urandom); rad_i = WB'($urandom);
        r_i = '0; g_i = '0; b_i = '0;
    endtask

    task automatic set_param(input logic [3:0] op, input logic [WB-1:0] x,
                             input logic [HB-1:0] y, input logic [WB-1:0] rad);
        idle_inputs();
        command_i = 1; write_enable_i = 1; opcode_i = op;
        if (op == 4'b0001) begin x1_i = x; y1_i = y; end
        if (op == 4'b0010) begin x2_i = x; y2_i = y; end
        if (op == 4'b0011) rad_i = rad;
        step();
        idle_inputs();
    endtask

    task automatic draw(input logic [3:0] op, input logic [CB-1:0] r,
                        input logic [CB-1:0] g, input logic [CB-1:0] b, input logic rdy);
        idle_inputs();
        command_i = 1; push_instruction_i = 1; opcode_i = op;
        r_i = r; g_i = g; b_i = b; instr_ready_i = rdy;
        step();
        idle_inputs();
    endtask

    task automatic soft_clear(input logic rdy);
        idle_inputs();
        command_i = 1; opcode_i = 4'b0000; instr_ready_i = rdy;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1;
        step();
        idle_inputs();
        checks++; if (count_o !== 4'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count_o); else passed++;
        checks++; if (instr_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid_o); else passed++;
        checks++; if (full_o !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", full_o); else passed++;
        checks++; if (overflow_o !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_o); else passed++;
    endtask

    task automatic test_basic_line();
        set_param(4'b0001, 10'd5, 9'd7, '0);
        set_param(4'b0010, 10'd100, 9'd50, '0);
        draw(4'b0100, 8'hFF, 8'h00, 8'h80, 0);
        checks++; if (instr_valid_o !== 1'b1) $display("[TB] FAIL line_valid: got %b expected 1", instr_valid_o); else passed++;
        checks++;
        if (head_bits() !== {4'h4, 10'd5, 9'd7, 10'd100, 9'd50, 10'd0, 8'hFF, 8'h00, 8'h80})
            $display("[TB] FAIL line_fields: got %h expected %h", head_bits(),
                     {4'h4, 10'd5, 9'd7, 10'd100, 9'd50, 10'd0, 8'hFF, 8'h00, 8'h80});
        else passed++;
        instr_ready_i = 1;
        step();
        idle_inputs();
        checks++; if (count_o !== 4'd0) $display("[TB] FAIL line_pop_count: got %0d expected 0", count_o); else passed++;
    endtask

    task automatic test_persistence();
        draw(4'b0101, 8'd1, 8'd2, 8'd3, 0);
        checks++;
        if (head_bits() !== {4'h5, 10'd5, 9'd7, 10'd100, 9'd50, 10'd0, 8'd1, 8'd2, 8'd3})
            $display("[TB] FAIL persist_fields: got %h expected %h", head_bits(),
                     {4'h5, 10'd5, 9'd7, 10'd100, 9'd50, 10'd0, 8'd1, 8'd2, 8'd3});
        else passed++;
        instr_ready_i = 1;
        step();
        idle_inputs();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) draw(4'b0100, 8'(i), 8'h00, 8'h00, 0);
        checks++; if (full_o !== 1'b1) $display("[TB] FAIL ovf_full: got %b expected 1", full_o); else passed++;
        checks++; if (count_o !== 4'd8) $display("[TB] FAIL ovf_count: got %0d expected 8", count_o); else passed++;
        checks++; if (overflow_o !== 1'b1) $display("[TB] FAIL ovf_flag: got %b expected 1", overflow_o); else passed++;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (instr_valid_o !== 1'b1 || instr_r_o !== 8'(i))
                $display("[TB] FAIL ovf_order_%0d: got valid=%b r=%0d expected valid=1 r=%0d", i, instr_valid_o, instr_r_o, i);
            else passed++;
            instr_ready_i = 1;
            step();
        end
        idle_inputs();
        checks++; if (instr_valid_o !== 1'b0 || count_o !== 4'd0)
            $display("[TB] FAIL ovf_drained: got valid=%b count=%0d expected valid=0 count=0", instr_valid_o, count_o);
        else passed++;
    endtask

    task automatic test_full_push_pop();
        logic [CB-1:0] expect_r [8];
        soft_clear(0);
        checks++; if (overflow_o !== 1'b0) $display("[TB] FAIL clear_overflow: got %b expected 0", overflow_o); else passed++;
        for (int i = 1; i <= 8; i++) draw(4'b0101, 8'(8'h10 + i), 8'h00, 8'h00, 0);
        draw(4'b0100, 8'hAA, 8'h00, 8'h00, 1);
        checks++; if (count_o !== 4'd8) $display("[TB] FAIL fullpp_count: got %0d expected 8", count_o); else passed++;
        checks++; if (overflow_o !== 1'b0) $display("[TB] FAIL fullpp_overflow: got %b expected 0", overflow_o); else passed++;
        for (int i = 0; i < 7; i++) expect_r[i] = 8'(8'h12 + i);
        expect_r[7] = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (instr_r_o !== expect_r[i])
                $display("[TB] FAIL fullpp_order_%0d: got r=%h expected r=%h", i, instr_r_o, expect_r[i]);
            else passed++;
            instr_ready_i = 1;
            step();
        end
        idle_inputs();
    endtask

    task automatic test_clear_and_reset();
        for (int pass = 0; pass < 2; pass++) begin
            set_param(4'b0001, 10'd33, 9'd44, '0);
            for (int i = 0; i < 3; i++) draw(4'b0100, 8'(i), 8'h5A, 8'hA5, 0);
            if (pass == 0) begin
                soft_clear(1);
            end else begin
                instr_ready_i = 1;
                rst_i = 1;
                step();
                idle_inputs();
            end
            checks++; if (count_o !== 4'd0 || instr_valid_o !== 1'b0)
                $display("[TB] FAIL clear%0d_empty: got count=%0d valid=%b expected 0/0", pass, count_o, instr_valid_o);
            else passed++;
            draw(4'b0100, 8'h01, 8'h02, 8'h03, 0);
            checks++; if (instr_x1_o !== 10'd0 || instr_y1_o !== 9'd0)
                $display("[TB] FAIL clear%0d_params: got x1=%0d y1=%0d expected 0/0", pass, instr_x1_o, instr_y1_o);
            else passed++;
            instr_ready_i = 1;
            step();
            idle_inputs();
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        int ready_pct;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ready_pct = (cyc < 200) ? 25 : 75;
            op = 4'($urandom_range(7));
            if (op == 4'b0000 && $urandom_range(9) != 0) op = 4'b0100;
            rst_i              = ($urandom_range(149) == 0);
            command_i          = 1'($urandom);
            opcode_i           = op;
            write_enable_i     = 1'($urandom);
            push_instruction_i = 1'($urandom);
            instr_ready_i      = ($urandom_range(99) < ready_pct);
            x1_i = WB'($urandom); y1_i = HB'($urandom);
            x2_i = WB'($urandom); y2_i = HB'($urandom); rad_i = WB'($urandom);
            r_i = CB'($urandom); g_i = CB'($urandom); b_i = CB'($urandom);
            step();
            checks++;
            if (count_o !== 4'(model_q.size()) || instr_valid_o !== (model_q.size() != 0) ||
                full_o !== (model_q.size() == DEPTH) || overflow_o !== m_ovf)
                $display("[TB] FAIL rand_status_%0d: got count=%0d valid=%b full=%b ovf=%b expected count=%0d ovf=%b",
                         cyc, count_o, instr_valid_o, full_o, overflow_o, model_q.size(), m_ovf);
            else passed++;
            if (model_q.size() != 0) begin
                checks++;
                if (head_bits() !== model_q[0])
                    $display("[TB] FAIL rand_head_%0d: got %h expected %h", cyc, head_bits(), model_q[0]);
                else passed++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_x1 = '0; m_y1 = '0; m_x2 = '0; m_y2 = '0; m_rad = '0; m_ovf = 1'b0;
        test_reset();
        test_basic_line();
        test_persistence();
        test_overflow();
        test_full_push_pop();
        test_clear_and_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
